// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation,
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  localparam int ADDRBITS_DEF = 8;

  // Conversions operate on a wide vector; zero-extended narrower pointers
  // convert correctly because the leading zeros contribute nothing.
  localparam int GW = 32;

  function automatic int fifo_depth(input int ab);
    return 1 << ab;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/write_ptr_full_if.sv
// Writer-side bundle of the async FIFO write pointer block.
interface write_ptr_full_if
  import fifo_pkg::*;
#(
  parameter int addrbits = ADDRBITS_DEF
) ();

  logic                sync_flush;
  logic                wr_en;
  logic [addrbits:0]   sync_rdptr;
  logic                wr_accept;
  logic [addrbits-1:0] waddr;
  logic [addrbits:0]   wrptr;
  logic                full;
  logic                almost_full;
  logic [addrbits:0]   wr_count;
  logic                overflow;

  modport master (
    output sync_flush, wr_en, sync_rdptr,
    input  wr_accept, waddr, wrptr, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  sync_flush, wr_en, sync_rdptr,
    output wr_accept, waddr, wrptr, full, almost_full, wr_count, overflow
  );

endinterface

// File: rtl/write_ptr_full.sv
// Write-domain pointer, full/almost-full, occupancy and sticky overflow
// generation for the asynchronous FIFO.
module write_ptr_full
  import fifo_pkg::*;
#(
  parameter int addrbits     = ADDRBITS_DEF,
  parameter int AFULL_MARGIN = 4
) (
  input logic              clk_out,
  input logic              rst,
  write_ptr_full_if.slave  bus
);

  localparam int DEPTH = fifo_depth(addrbits);
  localparam int PW    = addrbits + 1;
  localparam logic [PW-1:0] AFULL_TH = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wbin, wbin_next;
  logic [PW-1:0] wgray, wgray_next;
  logic [PW-1:0] rbin, count_next, count_q;
  logic          full_q, full_next;
  logic          afull_q, afull_next;
  logic          ovf_q;
  logic          clear;
  logic          accept;

  assign clear  = rst || bus.sync_flush;
  assign accept = bus.wr_en && !full_q && !clear;

  always_comb begin
    wbin_next  = wbin + PW'(accept);
    wgray_next = PW'(bin2gray(GW'(wbin_next)));
    rbin       = PW'(gray2bin(GW'(bus.sync_rdptr)));
    count_next = wbin_next - rbin;
    // Full: same RAM slot, writer one lap ahead (two Gray MSBs differ).
    full_next  = (wgray_next == {~bus.sync_rdptr[PW-1:PW-2], bus.sync_rdptr[PW-3:0]});
    afull_next = (count_next >= AFULL_TH);
  end

  always_ff @(posedge clk_out) begin
    if (clear) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= full_next;
      afull_q <= afull_next;
      count_q <= count_next;
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  assign bus.wr_accept   = accept;
  assign bus.waddr       = wbin[addrbits-1:0];
  assign bus.wrptr       = wgray;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wr_count    = count_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_write_ptr_full.sv
// Directed self-checking bench for write_ptr_full (addrbits=8, margin 4).
module tb_write_ptr_full;

  logic clk_out;
  logic rst;
  int   checks;
  int   failures;

  write_ptr_full_if #(.addrbits(8)) bus ();

  write_ptr_full #(.addrbits(8), .AFULL_MARGIN(4)) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  function automatic logic [8:0] gray9(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic fill_quiet();
    bus.wr_en = 1'b1;
    repeat (256) tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic flush();
    bus.sync_rdptr = '0;
    bus.sync_flush = 1'b1;
    tick();
    bus.sync_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.sync_flush = 1'b0;
    bus.sync_rdptr = '0;
    #1;
    checks++;
    if (bus.wr_accept !== 1'b0) begin
      failures++; $display("FAIL reset_accept got=%b exp=0", bus.wr_accept);
    end
    tick();
    tick();
    checks++;
    if ({bus.waddr, bus.wrptr, bus.wr_count} !== 26'd0) begin
      failures++;
      $display("FAIL reset_ptrs waddr=%h wrptr=%h cnt=%0d exp=0", bus.waddr, bus.wrptr, bus.wr_count);
    end
    checks++;
    if ({bus.full, bus.almost_full, bus.overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.full, bus.almost_full, bus.overflow});
    end
    rst = 1'b0;
    bus.wr_en = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    int af_at = -1;
    int early_full = 0;
    int rej = 0;
    for (int i = 0; i < 256; i++) begin
      bus.wr_en = 1'b1;
      #1;
      if (bus.wr_accept !== 1'b1) rej++;
      tick();
      if (bus.almost_full === 1'b1 && af_at < 0) af_at = int'(bus.wr_count);
      if (bus.full === 1'b1 && i != 255) early_full++;
    end
    bus.wr_en = 1'b0;
    checks++;
    if (rej != 0) begin failures++; $display("FAIL fill_accept rejected=%0d exp=0", rej); end
    checks++;
    if (af_at != 252) begin failures++; $display("FAIL fill_afull_at got=%0d exp=252", af_at); end
    checks++;
    if (early_full != 0) begin failures++; $display("FAIL fill_early_full got=%0d exp=0", early_full); end
    checks++;
    if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    checks++;
    if (bus.wr_count !== 9'd256) begin failures++; $display("FAIL fill_count got=%0d exp=256", bus.wr_count); end
    checks++;
    if (bus.wrptr !== 9'h180) begin failures++; $display("FAIL fill_wrptr got=%h exp=180", bus.wrptr); end
    checks++;
    if (bus.waddr !== 8'h00) begin failures++; $display("FAIL fill_waddr got=%h exp=00", bus.waddr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      #1;
      checks++;
      if (bus.wr_accept !== 1'b0) begin failures++; $display("FAIL ovf_accept got=%b exp=0", bus.wr_accept); end
      tick();
      checks++;
      if (bus.wrptr !== 9'h180 || bus.waddr !== 8'h00 || bus.overflow !== 1'b1) begin
        failures++;
        $display("FAIL ovf_state wrptr=%h waddr=%h ovf=%b exp 180/00/1", bus.wrptr, bus.waddr, bus.overflow);
      end
    end
    bus.wr_en = 1'b0;
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    flush();
    checks++;
    if ({bus.waddr, bus.wrptr, bus.wr_count, bus.full, bus.almost_full, bus.overflow} !== 29'd0) begin
      failures++;
      $display("FAIL ovf_flush waddr=%h wrptr=%h cnt=%0d f=%b af=%b ovf=%b exp=0",
               bus.waddr, bus.wrptr, bus.wr_count, bus.full, bus.almost_full, bus.overflow);
    end
  endtask

  task automatic test_release();
    fill_quiet();
    bus.sync_rdptr = 9'h001;
    tick();
    checks++;
    if (bus.full !== 1'b0 || bus.wr_count !== 9'd255) begin
      failures++; $display("FAIL rel_free full=%b cnt=%0d exp 0/255", bus.full, bus.wr_count);
    end
    bus.wr_en = 1'b1;
    #1;
    checks++;
    if (bus.wr_accept !== 1'b1) begin failures++; $display("FAIL rel_accept got=%b exp=1", bus.wr_accept); end
    tick();
    checks++;
    if (bus.full !== 1'b1 || bus.wr_count !== 9'd256) begin
      failures++; $display("FAIL rel_refull full=%b cnt=%0d exp 1/256", bus.full, bus.wr_count);
    end
    checks++;
    if (bus.wr_accept !== 1'b0) begin failures++; $display("FAIL rel_second_accept got=%b exp=0", bus.wr_accept); end
    tick();
    checks++;
    if (bus.waddr !== 8'h01 || bus.wrptr !== 9'h181) begin
      failures++; $display("FAIL rel_hold waddr=%h wrptr=%h exp 01/181", bus.waddr, bus.wrptr);
    end
    bus.wr_en = 1'b0;
    flush();
  endtask

  task automatic test_wrap();
    logic [8:0] prev;
    logic [8:0] rb;
    int bad_gray = 0;
    int saw_full = 0;
    prev = bus.wrptr;
    for (int i = 0; i < 1000; i++) begin
      rb = (i + 1 >= 10) ? 9'(i + 1 - 10) : 9'd0;
      bus.sync_rdptr = gray9(rb);
      bus.wr_en = 1'b1;
      tick();
      if ($countones(prev ^ bus.wrptr) != 1) bad_gray++;
      if (bus.full !== 1'b0) saw_full++;
      prev = bus.wrptr;
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bad_gray != 0) begin failures++; $display("FAIL wrap_gray_steps bad=%0d exp=0", bad_gray); end
    checks++;
    if (saw_full != 0) begin failures++; $display("FAIL wrap_full cycles=%0d exp=0", saw_full); end
    checks++;
    if (bus.wr_count !== 9'd10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", bus.wr_count); end
    checks++;
    if (bus.wrptr !== gray9(9'd488)) begin
      failures++; $display("FAIL wrap_wrptr got=%h exp=%h", bus.wrptr, gray9(9'd488));
    end
    flush();
  endtask

  task automatic test_reset_mid_burst();
    bus.wr_en = 1'b1;
    repeat (100) tick();
    checks++;
    if (bus.waddr !== 8'd100) begin failures++; $display("FAIL rmb_pre waddr=%0d exp=100", bus.waddr); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wr_accept !== 1'b0) begin failures++; $display("FAIL rmb_accept got=%b exp=0", bus.wr_accept); end
    tick();
    checks++;
    if (bus.waddr !== 8'd0 || bus.wrptr !== 9'd0 || bus.wr_count !== 9'd0) begin
      failures++; $display("FAIL rmb_clear waddr=%h wrptr=%h cnt=%0d exp 0", bus.waddr, bus.wrptr, bus.wr_count);
    end
    rst = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.waddr !== 8'd1 || bus.wrptr !== 9'd1) begin
      failures++; $display("FAIL rmb_restart waddr=%h wrptr=%h exp 01/001", bus.waddr, bus.wrptr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
